// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle barrel shifter, one log2 pass per cycle.
// Ports:
//   i_clk      clock, all state changes on rising edge
//   i_reset    synchronous active-high reset
//   i_start    request, sampled only when not busy (IDLE or DONE)
//   i_data     operand, captured on accepted start
//   i_shamt    unsigned shift amount, captured with i_data
//   i_dir      0 = logical left, 1 = logical right (SHIFT_SRL_EN only)
//   o_busy     high while shifting
//   o_done     one-cycle pulse with the updated result
//   o_data_out registered result, held until next completion
// Optional feature macro: SHIFT_SRL_EN adds i_dir and right shifts.
module shift_sequencer #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [DATA_W-1:0]  i_data,
   input  logic [SHAMT_W-1:0] i_shamt,
`ifdef SHIFT_SRL_EN
   input  logic               i_dir,
`endif
   output logic               o_busy,
   output logic               o_done,
   output logic [DATA_W-1:0]  o_data_out
);

   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_acc;
   logic [SHAMT_W-1:0]  r_amt;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_dir_q;
   logic                r_busy;
   logic                r_done;
   logic [DATA_W-1:0]   r_data_out;

   logic                w_dir;
   logic [SHAMT_W:0]    w_dist;
   logic                w_amt_bit;
   logic                w_last;
   logic [DATA_W-1:0]   w_pass;

`ifdef SHIFT_SRL_EN
   assign w_dir = i_dir;
`else
   // Left-only build: direction is permanently "left".
   assign w_dir = 1'b0;
`endif

   // Pass cnt moves the accumulator by 2**cnt when amt[cnt] is set.
   always_comb begin
      w_dist    = {{SHAMT_W{1'b0}}, 1'b1} << r_cnt;
      w_amt_bit = r_amt[r_cnt];
      w_last    = (r_cnt == CNT_W'(SHAMT_W - 1));
      w_pass    = r_acc;
      if (w_amt_bit) begin
         if (r_dir_q) w_pass = r_acc >> w_dist;
         else         w_pass = r_acc << w_dist;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= IDLE;
         r_acc      <= '0;
         r_amt      <= '0;
         r_cnt      <= '0;
         r_dir_q    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_data_out <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_acc   <= i_data;
                  r_amt   <= i_shamt;
                  r_cnt   <= '0;
                  r_dir_q <= w_dir;
                  r_busy  <= 1'b1;
                  r_state <= SHIFT;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            SHIFT: begin
               // Always SHAMT_W passes, even when the amount is 0.
               r_acc <= w_pass;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_data_out <= w_pass;
                  r_done     <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_data_out = r_data_out;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scoreboard bench for shift_sequencer.
// Expected results are queued at start and popped on each done pulse.
module tb_shift_sequencer;

   localparam int DW = 32;
   localparam int SW = 5;

   logic          clk = 1'b0;
   logic          i_reset;
   logic          i_start;
   logic [DW-1:0] i_data;
   logic [SW-1:0] i_shamt;
   logic          i_dir;
   logic          o_busy;
   logic          o_done;
   logic [DW-1:0] o_data_out;

   int            n_chk  = 0;
   int            n_fail = 0;
   logic [DW-1:0] sb_q[$];
   logic [DW-1:0] last_exp = '0;

   always #5 clk = ~clk;

   shift_sequencer #(.DATA_W(DW), .SHAMT_W(SW)) dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_start    (i_start),
      .i_data     (i_data),
      .i_shamt    (i_shamt),
`ifdef SHIFT_SRL_EN
      .i_dir      (i_dir),
`endif
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_data_out (o_data_out)
   );

   task automatic chk(input string tag,
                      input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] model(input logic [DW-1:0] d,
                                           input logic [SW-1:0] s,
                                           input logic dr);
      return dr ? (d >> s) : (d << s);
   endfunction

   // Scoreboard: every done pulse must match the oldest queued result.
   always @(negedge clk) begin
      if (o_done) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_done", 1, 0);
         end else begin
            last_exp = sb_q.pop_front();
            chk("sb_data", o_data_out, last_exp);
         end
      end
   end

   // One request, with an optional ignored second start at poke_k.
   task automatic op(input logic [DW-1:0] d, input logic [SW-1:0] s,
                     input logic dr, input int poke_k,
                     output int done_at, output int busy_n,
                     output int done_n);
      @(negedge clk);
      i_data  = d;
      i_shamt = s;
      i_dir   = dr;
      i_start = 1'b1;
      sb_q.push_back(model(d, s, dr));
      @(posedge clk);
      #1 i_start = 1'b0;
      busy_n  = 0;
      done_n  = 0;
      done_at = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (o_busy) busy_n++;
         if (o_done) begin
            done_n++;
            if (done_at < 0) done_at = k;
         end
         if (k == poke_k) begin
            i_start = 1'b1;
            i_data  = 32'h1;
            i_shamt = 5'd1;
         end else if (k == poke_k + 1) begin
            i_start = 1'b0;
         end
      end
   endtask

   initial begin
      int da, bn, dn;
      int d1, d2, dcount;
      logic [DW-1:0] rd;
      logic [SW-1:0] rs;
      i_reset = 1'b1;
      i_start = 1'b0;
      i_data  = '0;
      i_shamt = '0;
      i_dir   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_dout", o_data_out, 0);
      i_reset = 1'b0;

      // 1 << 31: latency, busy length, single pulse
      op(32'h1, 5'd31, 1'b0, -1, da, bn, dn);
      chk("max_lat", da, 5);
      chk("max_busy", bn, 5);
      chk("max_pulses", dn, 1);
      chk("max_hold", o_data_out, 32'h8000_0000);

      // shamt = 0 still takes the full pass count
      op(32'hDEAD_BEEF, 5'd0, 1'b0, -1, da, bn, dn);
      chk("zero_lat", da, 5);
      chk("zero_pulses", dn, 1);
      chk("zero_hold", o_data_out, 32'hDEAD_BEEF);

      // start during SHIFT is ignored
      op(32'hFF, 5'd4, 1'b0, 2, da, bn, dn);
      chk("ign_lat", da, 5);
      chk("ign_pulses", dn, 1);
      chk("ign_hold", o_data_out, 32'h0000_0FF0);

      // back-to-back with start held high
      @(negedge clk);
      i_data  = 32'h1;
      i_shamt = 5'd1;
      i_dir   = 1'b0;
      i_start = 1'b1;
      sb_q.push_back(32'h2);
      sb_q.push_back(32'hC);
      @(posedge clk);
      #1;
      i_data  = 32'h3;
      i_shamt = 5'd2;
      d1 = -1;
      d2 = -1;
      dcount = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (o_done) begin
            dcount++;
            if (d1 < 0) d1 = k;
            else if (d2 < 0) d2 = k;
         end
         if (k == 6) i_start = 1'b0;
      end
      chk("b2b_first", d1, 5);
      chk("b2b_gap", d2 - d1, 6);
      chk("b2b_pulses", dcount, 2);
      chk("b2b_hold", o_data_out, 32'hC);

      // reset in the third SHIFT cycle aborts the operation
      @(negedge clk);
      i_data  = 32'hFFFF_FFFF;
      i_shamt = 5'd8;
      i_start = 1'b1;
      @(posedge clk);
      #1 i_start = 1'b0;
      repeat (3) @(negedge clk);
      i_reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", o_busy, 0);
      chk("abort_done", o_done, 0);
      chk("abort_dout", o_data_out, 0);
      i_reset = 1'b0;
      dcount = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (o_done) dcount++;
      end
      chk("abort_pulses", dcount, 0);

      // reset wins over a simultaneous start
      @(negedge clk);
      i_reset = 1'b1;
      i_start = 1'b1;
      i_data  = 32'h5;
      @(negedge clk);
      i_reset = 1'b0;
      i_start = 1'b0;
      chk("rst_win_busy", o_busy, 0);
      @(negedge clk);
      chk("rst_win_busy2", o_busy, 0);

`ifdef SHIFT_SRL_EN
      op(32'h8000_0000, 5'd31, 1'b1, -1, da, bn, dn);
      chk("srl_max", o_data_out, 32'h0000_0001);
      op(32'hF000_000F, 5'd4, 1'b1, -1, da, bn, dn);
      chk("srl_4", o_data_out, 32'h0F00_0000);
`endif

      // random operands
      for (int n = 0; n < 8; n++) begin
         rd = DW'($urandom);
         rs = SW'($urandom_range(0, DW - 1));
`ifdef SHIFT_SRL_EN
         op(rd, rs, 1'($urandom_range(0, 1)), -1, da, bn, dn);
`else
         op(rd, rs, 1'b0, -1, da, bn, dn);
`endif
         chk("rnd_pulses", dn, 1);
      end

      chk("sb_left", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; SHALL equal 2**SHAMT_W.
REQ-002 Parameter SHAMT_W, default 5, shift-amount width and number of shift passes.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 start  input  1  request; sampled only when the block is not busy.
REQ-006 data  input  DATA_W  operand, captured when start is accepted.
REQ-007 shamt  input  SHAMT_W  unsigned shift amount, captured with data.
REQ-008 dir  input  1  0 = logical left, 1 = logical right; present only with SHIFT_SRL_EN.
REQ-009 busy  output  1  high while in state SHIFT.
REQ-010 done  output  1  one-cycle pulse; dataOut valid and updated in the same cycle.
REQ-011 dataOut  output  DATA_W  registered result; holds until the next completion.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE, with internal regs acc[DATA_W], amt[SHAMT_W], cnt[3] and dir_q.
REQ-013 start SHALL be accepted in IDLE or DONE: capture acc<=data, amt<=shamt, cnt<=0, dir_q<=dir (else 0), next state SHIFT.
REQ-014 start SHALL be ignored in SHIFT; captured operands SHALL NOT change.
REQ-015 In SHIFT, each cycle SHALL apply pass cnt: acc shifted by 2**cnt when amt[cnt]=1, else unchanged; then cnt<=cnt+1.
REQ-016 Vacated bit positions SHALL be filled with 0; bits shifted beyond the width SHALL be discarded.
REQ-017 On the pass with cnt=SHAMT_W-1, the final value SHALL be written to dataOut and the state SHALL move to DONE.
REQ-018 Latency: start accepted at edge N gives done=1 and the new dataOut in the cycle after edge N+SHAMT_W (5 for the defaults).
REQ-019 The pass count SHALL be fixed at SHAMT_W regardless of shamt value, including shamt=0.
REQ-020 done SHALL be high only in DONE; DONE SHALL last exactly one cycle, then go to IDLE, or to SHIFT if start=1.
REQ-021 Back-to-back: start held high SHALL give one result every SHAMT_W+1 cycles.
REQ-022 shamt=0 SHALL give dataOut=data; shamt=DATA_W-1 left SHALL give dataOut={data[0], zeros}.

Reset
REQ-023 Sampled reset=1 SHALL force IDLE, busy=0, done=0, dataOut=0, acc=0, amt=0, cnt=0, dir_q=0.
REQ-024 Reset during SHIFT SHALL abort the operation with no done pulse; dataOut SHALL read 0.
REQ-025 When reset and start are both high at the same edge, reset SHALL win and start SHALL be dropped.

Configuration
REQ-026 Macro SHIFT_SRL_EN defined: port dir exists; dir_q=1 selects logical right shift for every pass.
REQ-027 Macro SHIFT_SRL_EN undefined: port dir absent; dir_q tied 0; only left shift is implemented.

Verification
REQ-028 reset 2 cycles; data=0x0000_0001, shamt=31, start 1 cycle -> done pulse 5 cycles later; dataOut=0x8000_0000; busy high 5 cycles.
REQ-029 data=0xDEAD_BEEF, shamt=0 -> dataOut=0xDEAD_BEEF after 5 cycles, single done pulse.
REQ-030 data=0x0000_00FF, shamt=4, then start pulsed mid-SHIFT with data=0x1, shamt=1 -> dataOut=0x0000_0FF0; second request ignored.
REQ-031 start held high, ops (0x1,1) then (0x3,2) -> dataOut 0x2 then 0xC; done pulses 6 cycles apart.
REQ-032 start with data=0xFFFF_FFFF, shamt=8; reset asserted in the third SHIFT cycle -> no done pulse; dataOut=0; busy=0 next cycle.
REQ-033 SHIFT_SRL_EN: data=0x8000_0000, shamt=31, dir=1 -> dataOut=0x0000_0001; data=0xF000_000F, shamt=4, dir=1 -> 0x0F00_0000.
